// File: rtl/pokey_pot_scanner.sv
// POKEY paddle scan engine: counts scan lines after POTGO and latches, per pot,
// the line count at which its comparator input rose. Exposes POTn and ALLPOT.

module pokey_pot_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             step,
  input  logic             at_max,
  input  logic             pot_in,
  input  logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic [CNT_W-1:0] val
);
  logic             active_q, active_d;
  logic [CNT_W-1:0] val_q, val_d;

  // At terminal count cnt already equals POT_MAX, so latching cnt covers both cases.
  always_comb begin
    active_d = active_q;
    val_d    = val_q;
    if (arm) begin
      active_d = 1'b1;
    end else if (step && active_q && (at_max || pot_in)) begin
      val_d    = cnt;
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      val_q    <= '0;
    end else begin
      active_q <= active_d;
      val_q    <= val_d;
    end
  end

  assign active = active_q;
  assign val    = val_q;
endmodule

module pokey_pot_scanner #(
  parameter int POT_MAX = 228,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_179,
  input  logic             enable_15,
  input  logic             fast_mode,
  input  logic             potgo,
  input  logic [7:0]       pot_in,
  input  logic [2:0]       pot_sel,
  output logic [CNT_W-1:0] pot_value,
  output logic [7:0]       allpot,
  output logic             pot_reset,
  output logic             scanning
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic                                  tick, step, at_max;
  logic [NUM_LANES-1:0][CNT_W-1:0]       pot_reg;

  assign tick   = fast_mode ? enable_179 : enable_15;
  // potgo pre-empts a coincident tick: no latch, no increment that cycle.
  assign step   = (state_q == SCAN) && tick && !potgo;
  assign at_max = (cnt_q == CNT_W'(POT_MAX));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (potgo) begin
      state_d = SCAN;
      cnt_d   = '0;
    end else if (step) begin
      if (at_max) state_d = IDLE;
      else        cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pokey_pot_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .arm     (potgo),
      .step    (step),
      .at_max  (at_max),
      .pot_in  (pot_in[i]),
      .cnt     (cnt_q),
      .active  (allpot[i]),
      .val     (pot_reg[i])
    );
  end

  assign pot_value = pot_reg[pot_sel];
  assign scanning  = (state_q == SCAN);
  assign pot_reset = (state_q == IDLE);
endmodule
